// File: rtl/goertzel_tone_gen.sv
// Burst sine generator built on the Goertzel resonator y[n] = alpha*y[n-1] - y[n-2].
// State is Q20.44; samples leave as saturated Q8.24, one per valid/ready handshake.
module goertzel_tone_gen #(
  parameter int NS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [31:0] alpha_i,
  input  logic signed [31:0] sin_i,
  input  logic signed [31:0] amp_i,
  output logic               busy,
  output logic               done,
  output logic               valid,
  input  logic               ready,
  output logic signed [31:0] data_o
);

  localparam int CW = $clog2(NS) + 1;
  localparam logic [CW-1:0] LAST = CW'(NS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic signed [31:0] alpha_r, sin_r, amp_r;
  logic signed [63:0] y_cur_r, y_prev_r, y_cur_s, y_prev_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic               latch_s;
  logic               busy_r, done_r, valid_r;
  logic               busy_s, done_s, valid_s;
  logic signed [31:0] data_r, data_s;
  logic signed [63:0] alpha_ext_s;
  logic signed [63:0] init_prod_s;
  logic signed [127:0] rec_prod_s;

  // Q8.24 -> Q20.44 by sign extension and a 20-bit left alignment
  function automatic logic signed [63:0] ext_q(input logic signed [31:0] x);
    return {{12{x[31]}}, x, 20'd0};
  endfunction

  // top holds y[63:20]; in range when y[63:51] are all equal
  function automatic logic signed [31:0] sat(input logic [43:0] top);
    if ((&top[43:31]) || !(|top[43:31])) begin
      return top[31:0];
    end else if (top[43]) begin
      return 32'sh8000_0000;
    end else begin
      return 32'sh7FFF_FFFF;
    end
  endfunction

  assign alpha_ext_s = ext_q(alpha_r);
  assign init_prod_s = $signed({{32{amp_r[31]}}, amp_r}) * $signed({{32{sin_r[31]}}, sin_r});
  assign rec_prod_s  = $signed({{64{alpha_ext_s[63]}}, alpha_ext_s})
                     * $signed({{64{y_cur_r[63]}}, y_cur_r});

  // Next-state and datapath update
  always_comb begin
    state_s  = state_r;
    y_cur_s  = y_cur_r;
    y_prev_s = y_prev_r;
    cnt_s    = cnt_r;
    latch_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          latch_s = 1'b1;
          state_s = INIT;
        end else begin
          state_s = IDLE;
        end
      end
      INIT: begin
        y_prev_s = 64'sd0;
        y_cur_s  = init_prod_s >>> 4;
        cnt_s    = {CW{1'b0}};
        state_s  = RUN;
      end
      RUN: begin
        if (ready) begin
          y_prev_s = y_cur_r;
          y_cur_s  = 64'(rec_prod_s >>> 7'd44) - y_prev_r;
          cnt_s    = cnt_r + CW'(1);
          if (cnt_r == LAST) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Outputs are derived from the next state so they can be registered without extra latency
  always_comb begin
    valid_s = (state_s == RUN);
    done_s  = (state_s == DONE);
    busy_s  = (state_s != IDLE);
    if (state_s == RUN) begin
      data_s = sat(y_prev_s[63:20]);
    end else begin
      data_s = 32'sd0;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      alpha_r  <= 32'sd0;
      sin_r    <= 32'sd0;
      amp_r    <= 32'sd0;
      y_cur_r  <= 64'sd0;
      y_prev_r <= 64'sd0;
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      valid_r  <= 1'b0;
      data_r   <= 32'sd0;
    end else begin
      state_r  <= state_s;
      y_cur_r  <= y_cur_s;
      y_prev_r <= y_prev_s;
      cnt_r    <= cnt_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      valid_r  <= valid_s;
      data_r   <= data_s;
      if (latch_s) begin
        alpha_r <= alpha_i;
        sin_r   <= sin_i;
        amp_r   <= amp_i;
      end else begin
        alpha_r <= alpha_r;
        sin_r   <= sin_r;
        amp_r   <= amp_r;
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign valid  = valid_r;
  assign data_o = data_r;

endmodule

// File: tb/tb_goertzel_tone_gen.sv
// Bench for goertzel_tone_gen: three instances (NS = 8, 4, 1) checked against a
// Q20.44 burst model plus directed cycle-exact expectations.
module tb_goertzel_tone_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alpha, sn, amp;
  logic        st [3];
  logic        rd [3];
  logic        bz [3];
  logic        dn [3];
  logic        vl [3];
  logic [31:0] dat [3];

  always #5 clk = ~clk;

  goertzel_tone_gen #(.NS(8)) u8 (
    .clk(clk), .rst(rst), .start(st[0]), .alpha_i(alpha), .sin_i(sn), .amp_i(amp),
    .busy(bz[0]), .done(dn[0]), .valid(vl[0]), .ready(rd[0]), .data_o(dat[0]));
  goertzel_tone_gen #(.NS(4)) u4 (
    .clk(clk), .rst(rst), .start(st[1]), .alpha_i(alpha), .sin_i(sn), .amp_i(amp),
    .busy(bz[1]), .done(dn[1]), .valid(vl[1]), .ready(rd[1]), .data_o(dat[1]));
  goertzel_tone_gen #(.NS(1)) u1 (
    .clk(clk), .rst(rst), .start(st[2]), .alpha_i(alpha), .sin_i(sn), .amp_i(amp),
    .busy(bz[2]), .done(dn[2]), .valid(vl[2]), .ready(rd[2]), .data_o(dat[2]));

  int checks = 0;
  int errors = 0;

  logic [31:0] expv [3][16];
  int          explen [3] = '{0, 0, 0};
  int          idx [3]    = '{0, 0, 0};
  int          dcnt [3]   = '{0, 0, 0};
  logic        pstall [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] pdat [3];

  logic [31:0] la [8] = '{32'h0, 32'h0100_0000, 32'h0, 32'hFF00_0000,
                          32'h0, 32'h0100_0000, 32'h0, 32'hFF00_0000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Clamp a Q20.44 value to the Q8.24 range, then drop the 20 extra fraction bits
  function automatic logic [31:0] msat(input longint y);
    if (y >= 64'sh0008_0000_0000_0000) return 32'h7FFF_FFFF;
    if (y < -64'sh0008_0000_0000_0000) return 32'h8000_0000;
    return y[51:20];
  endfunction

  task automatic gen_burst(input int id, input logic [31:0] a, input logic [31:0] s,
                           input logic [31:0] m, input int ns);
    longint yp, yc, yn;
    logic signed [127:0] t;
    yp = 0;
    yc = (longint'($signed(m)) * longint'($signed(s))) >>> 4;
    for (int n = 0; n < ns; n++) begin
      expv[id][n] = msat(yp);
      t  = (128'(longint'($signed(a))) <<< 20) * 128'(yc);
      yn = longint'(t >>> 44) - yp;
      yp = yc;
      yc = yn;
    end
    explen[id] = ns;
  endtask

  // Per-instance scoreboard: every valid cycle must show the next expected sample
  task automatic mon(input int i);
    if (vl[i]) begin
      if (idx[i] >= explen[i]) begin
        chk($sformatf("overrun_u%0d", i), 32'(idx[i]), 32'(explen[i] - 1));
      end else begin
        chk($sformatf("sample%0d_u%0d", idx[i], i), dat[i], expv[i][idx[i]]);
      end
      if (pstall[i]) chk($sformatf("stall_hold_u%0d", i), dat[i], pdat[i]);
    end else if (pstall[i]) begin
      chk($sformatf("stall_valid_u%0d", i), 32'(vl[i]), 32'd1);
    end
    if (dn[i]) begin
      chk($sformatf("done_after_last_u%0d", i), {31'd0, vl[i]} + 32'(idx[i]), 32'(explen[i]));
      dcnt[i]++;
    end
    pstall[i] = !rst && vl[i] && !rd[i];
    pdat[i]   = dat[i];
    if (rst) begin
      idx[i] = 0;
    end else if (st[i] && !bz[i]) begin
      idx[i] = 0;
    end else if (vl[i] && rd[i]) begin
      idx[i]++;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) mon(i);
  end

  task automatic set_coef(input logic [31:0] a, input logic [31:0] s, input logic [31:0] m);
    alpha = a;
    sn    = s;
    amp   = m;
  endtask

  task automatic start_burst(input int i);
    @(posedge clk); #1;
    st[i] = 1'b1;
    @(posedge clk); #1;
    st[i] = 1'b0;
  endtask

  task automatic run_a();
    set_coef(32'h0, 32'h0100_0000, 32'h0100_0000);
    gen_burst(0, 32'h0, 32'h0100_0000, 32'h0100_0000, 8);
    rd[0] = 1'b1;
    start_burst(0);
    @(negedge clk) chk("a_init_cycle", {30'd0, vl[0], bz[0]}, 32'd1);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk) chk($sformatf("a_seq%0d", j), vl[0] ? dat[0] : 32'hDEAD_BEEF, la[j]);
    end
    @(negedge clk) chk("a_done_pulse", {30'd0, dn[0], vl[0]}, 32'd2);
    @(negedge clk) chk("a_done_once", {30'd0, dn[0], bz[0]}, 32'd0);
  endtask

  initial begin
    int d0, n;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      rd[i] = 1'b0;
    end
    set_coef(32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle with start low
    repeat (20) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        chk($sformatf("idle_u%0d", i), {29'd0, vl[i], dn[i], bz[i]} | dat[i], 32'd0);
    end

    // Model pinned to hand-derived values
    gen_burst(0, 32'h0, 32'h0100_0000, 32'h0100_0000, 8);
    chk("model_a1", expv[0][1], 32'h0100_0000);
    chk("model_a3", expv[0][3], 32'hFF00_0000);
    chk("model_a4", expv[0][4], 32'h0);
    gen_burst(1, 32'h0200_0000, 32'h0100_0000, 32'h6400_0000, 4);
    chk("model_c0", expv[1][0], 32'h0);
    chk("model_c1", expv[1][1], 32'h6400_0000);
    chk("model_c2", expv[1][2], 32'h7FFF_FFFF);
    chk("model_c3", expv[1][3], 32'h7FFF_FFFF);

    // Burst with ready held high
    run_a();

    // Same burst under a random ready pattern
    d0 = dcnt[0];
    gen_burst(0, 32'h0, 32'h0100_0000, 32'h0100_0000, 8);
    rd[0] = 1'b0;
    start_burst(0);
    n = 0;
    while (dcnt[0] == d0 && n < 300) begin
      rd[0] = ($urandom_range(0, 9) >= 4);
      @(posedge clk); #1;
      n++;
    end
    rd[0] = 1'b1;
    chk("rand_done_count", 32'(dcnt[0]), 32'(d0 + 1));
    chk("rand_transfers", 32'(idx[0]), 32'd8);
    repeat (4) @(posedge clk);
    chk("rand_no_extra_done", 32'(dcnt[0]), 32'(d0 + 1));

    // Ignored start during RUN, then reset after sample 3, then restart
    d0 = dcnt[0];
    set_coef(32'h0, 32'h0100_0000, 32'h0100_0000);
    rd[0] = 1'b1;
    start_burst(0);
    @(negedge clk) chk("d_init_cycle", {30'd0, vl[0], bz[0]}, 32'd1);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      st[0] = (j == 1);
      @(negedge clk) chk($sformatf("d_seq%0d", j), vl[0] ? dat[0] : 32'hDEAD_BEEF, la[j]);
    end
    @(posedge clk); #1;
    st[0] = 1'b0;
    rst   = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk) chk("d_abort", {29'd0, vl[0], bz[0], dn[0]}, 32'd0);
    repeat (5) @(negedge clk);
    chk("d_no_done", 32'(dcnt[0]), 32'(d0));
    run_a();

    // Saturating ramp, NS = 4
    d0 = dcnt[1];
    set_coef(32'h0200_0000, 32'h0100_0000, 32'h6400_0000);
    rd[1] = 1'b1;
    start_burst(1);
    n = 0;
    while (dcnt[1] == d0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("c_done_count", 32'(dcnt[1]), 32'(d0 + 1));
    chk("c_transfers", 32'(idx[1]), 32'd4);

    // NS = 1 with start held high back to back
    d0 = dcnt[2];
    set_coef(32'h0, 32'h0100_0000, 32'h0100_0000);
    gen_burst(2, 32'h0, 32'h0100_0000, 32'h0100_0000, 1);
    rd[2] = 1'b1;
    @(posedge clk); #1;
    st[2] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk) chk("e_init", {30'd0, vl[2], bz[2]}, 32'd1);
    @(negedge clk) chk("e_sample", vl[2] ? dat[2] : 32'hDEAD_BEEF, 32'h0);
    @(negedge clk) chk("e_done", {30'd0, dn[2], vl[2]}, 32'd2);
    @(negedge clk) chk("e_idle", {30'd0, dn[2], bz[2]}, 32'd0);
    @(negedge clk) chk("e_reaccept", {30'd0, vl[2], bz[2]}, 32'd1);
    @(posedge clk); #1;
    st[2] = 1'b0;
    @(negedge clk) chk("e_sample2", vl[2] ? dat[2] : 32'hDEAD_BEEF, 32'h0);
    @(negedge clk) chk("e_done2", {31'd0, dn[2]}, 32'd1);
    @(negedge clk) chk("e_done_count", 32'(dcnt[2]), 32'(d0 + 2));

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
